// File: rtl/chimera_clu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// chimera_clu_clk_ctrl
//
// Per-cluster clock-gating sequencer. Each cluster runs its own four-state FSM:
//   RUN   : clock running, isolation released.
//   DRAIN : isolation raised. Waits for IdleCycles consecutive idle cycles.
//           Aborts on timeout (sets a sticky error) or when the request drops.
//   GATED : clock stopped, isolation held.
//   WAKE  : clock running again, isolation held for WakeCycles cycles so the
//           cluster settles before it sees new traffic.
//
// Ports (one bit per cluster on every vector):
//   clk_i          SoC clock
//   rst_ni         asynchronous active-low reset
//   gate_req_i     level request: 1 = want clock gated, 0 = want running
//   clu_idle_i     cluster has no outstanding transactions (clk_i domain)
//   err_clr_i      single-cycle pulse that clears the sticky timeout error
//   clu_clk_en_o   enable to the cluster clock gate (1 = clock runs)
//   clu_isolate_o  1 = cluster AXI ports isolated
//   gated_o        1 only while in GATED
//   err_timeout_o  sticky drain-timeout error
//
// All outputs are decoded from flops only, so nothing on an input reaches an
// output in the same cycle. The per-cluster state lives in g_clu[i].state_q.
// -----------------------------------------------------------------------------
module chimera_clu_clk_ctrl #(
    parameter  int unsigned NumClusters   = 5,
    parameter  int unsigned IdleCycles    = 4,
    parameter  int unsigned WakeCycles    = 3,
    parameter  int unsigned TimeoutCycles = 16,
    // Counter width is derived from the largest count it has to reach.
    localparam int unsigned IdleWakeMax   = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles,
    localparam int unsigned CntMaxVal     = (IdleWakeMax > TimeoutCycles) ? IdleWakeMax : TimeoutCycles,
    localparam int unsigned CntWidth      = $clog2(CntMaxVal + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumClusters-1:0] gate_req_i,
    input  logic [NumClusters-1:0] clu_idle_i,
    input  logic [NumClusters-1:0] err_clr_i,
    output logic [NumClusters-1:0] clu_clk_en_o,
    output logic [NumClusters-1:0] clu_isolate_o,
    output logic [NumClusters-1:0] gated_o,
    output logic [NumClusters-1:0] err_timeout_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntMax   = '1;
    localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] WakeLast = CntWidth'(WakeCycles - 1);
    // With TimeoutCycles == 0 the timeout branch is disabled, so the value
    // of TmoLast does not matter; 0 just keeps it in range.
    localparam bit                  TmoEn    = (TimeoutCycles != 0);
    localparam logic [CntWidth-1:0] TmoLast  = CntWidth'(TmoEn ? TimeoutCycles - 1 : 0);

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    for (genvar i = 0; i < NumClusters; i++) begin : g_clu
        state_e              state_q;
        logic [CntWidth-1:0] idle_cnt_q;
        logic [CntWidth-1:0] tmo_cnt_q;
        logic [CntWidth-1:0] wake_cnt_q;
        logic                err_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q    <= ST_RUN;
                idle_cnt_q <= '0;
                tmo_cnt_q  <= '0;
                wake_cnt_q <= '0;
                err_q      <= 1'b0;
            end else begin
                // A timeout in the same cycle overrides this clear below.
                if (err_clr_i[i]) begin
                    err_q <= 1'b0;
                end

                case (state_q)
                    ST_RUN: begin
                        if (gate_req_i[i] && !err_q) begin
                            state_q    <= ST_DRAIN;
                            idle_cnt_q <= '0;
                            tmo_cnt_q  <= '0;
                        end
                    end

                    ST_DRAIN: begin
                        idle_cnt_q <= clu_idle_i[i] ? sat_inc(idle_cnt_q) : '0;
                        tmo_cnt_q  <= sat_inc(tmo_cnt_q);
                        // Completing the drain beats a timeout landing on the
                        // same cycle, which in turn beats a dropped request.
                        if (clu_idle_i[i] && (idle_cnt_q == IdleLast)) begin
                            state_q <= ST_GATED;
                        end else if (TmoEn && (tmo_cnt_q == TmoLast)) begin
                            state_q <= ST_RUN;
                            err_q   <= 1'b1;
                        end else if (!gate_req_i[i]) begin
                            state_q <= ST_RUN;
                        end
                    end

                    ST_GATED: begin
                        if (!gate_req_i[i]) begin
                            state_q    <= ST_WAKE;
                            wake_cnt_q <= '0;
                        end
                    end

                    ST_WAKE: begin
                        // The request is not looked at here; RUN re-evaluates it.
                        wake_cnt_q <= sat_inc(wake_cnt_q);
                        if (wake_cnt_q == WakeLast) begin
                            state_q <= ST_RUN;
                        end
                    end

                    default: state_q <= ST_RUN;
                endcase
            end
        end

        assign clu_clk_en_o[i]  = (state_q != ST_GATED);
        assign clu_isolate_o[i] = (state_q != ST_RUN);
        assign gated_o[i]       = (state_q == ST_GATED);
        assign err_timeout_o[i] = err_q;
    end

endmodule

// File: tb/tb_chimera_clu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for chimera_clu_clk_ctrl. Two instances share clock and reset:
//   dut   : default parameters (5 clusters, idle 4, wake 3, timeout 16)
//   dut_b : one cluster with TimeoutCycles == IdleCycles == 4
// Directed tasks check fixed cycle positions; the independence and random
// tasks compare every cycle against a behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_chimera_clu_clk_ctrl;

    localparam int NC = 5;
    localparam int IC = 4;
    localparam int WC = 3;
    localparam int TC = 16;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_GATED = 2;
    localparam int M_WAKE  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NC-1:0] gate_req, clu_idle, err_clr;
    logic [NC-1:0] clk_en, iso, gated, err;
    logic          b_gate, b_idle, b_clr;
    logic          b_clk_en, b_iso, b_gated, b_err;

    int checks   = 0;
    int failures = 0;

    chimera_clu_clk_ctrl #(
        .NumClusters  (NC),
        .IdleCycles   (IC),
        .WakeCycles   (WC),
        .TimeoutCycles(TC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .gate_req_i   (gate_req),
        .clu_idle_i   (clu_idle),
        .err_clr_i    (err_clr),
        .clu_clk_en_o (clk_en),
        .clu_isolate_o(iso),
        .gated_o      (gated),
        .err_timeout_o(err)
    );

    chimera_clu_clk_ctrl #(
        .NumClusters  (1),
        .IdleCycles   (4),
        .WakeCycles   (3),
        .TimeoutCycles(4)
    ) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .gate_req_i   (b_gate),
        .clu_idle_i   (b_idle),
        .err_clr_i    (b_clr),
        .clu_clk_en_o (b_clk_en),
        .clu_isolate_o(b_iso),
        .gated_o      (b_gated),
        .err_timeout_o(b_err)
    );

    // ---------------- reference model ----------------
    // mode plus "how long has this phase lasted" counts, as plain integers.
    typedef struct packed {
        int   mode;
        int   run;   // consecutive idle cycles seen while draining
        int   age;   // cycles spent draining
        int   wage;  // cycles spent waking
        logic err;
    } mstate_t;

    mstate_t m [NC];

    function automatic mstate_t model_step(mstate_t s, logic req, logic idle, logic clr);
        mstate_t n;
        int      r;
        n = s;
        if (clr) n.err = 1'b0;
        case (s.mode)
            M_RUN: begin
                if (req && !s.err) begin
                    n.mode = M_DRAIN;
                    n.run  = 0;
                    n.age  = 0;
                end
            end
            M_DRAIN: begin
                r     = idle ? s.run + 1 : 0;
                n.run = r;
                n.age = s.age + 1;
                if (idle && r >= IC) n.mode = M_GATED;
                else if (TC != 0 && s.age + 1 >= TC) begin
                    n.mode = M_RUN;
                    n.err  = 1'b1;
                end else if (!req) n.mode = M_RUN;
            end
            M_GATED: begin
                if (!req) begin
                    n.mode = M_WAKE;
                    n.wage = 0;
                end
            end
            default: begin
                n.wage = s.wage + 1;
                if (s.wage + 1 >= WC) n.mode = M_RUN;
            end
        endcase
        return n;
    endfunction

    // {clk_en, iso, gated, err} as the model expects them.
    function automatic logic [4*NC-1:0] model_outs();
        logic [4*NC-1:0] o;
        o = '0;
        for (int c = 0; c < NC; c++) begin
            o[3*NC + c] = (m[c].mode != M_GATED);
            o[2*NC + c] = (m[c].mode != M_RUN);
            o[NC + c]   = (m[c].mode == M_GATED);
            o[c]        = m[c].err;
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) m[c] <= '0;
        end else begin
            for (int c = 0; c < NC; c++)
                m[c] <= model_step(m[c], gate_req[c], clu_idle[c], err_clr[c]);
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        checks++;
        if (clk_en !== '1 || iso !== '0 || gated !== '0 || err !== '0) begin
            failures++;
            $display("FAIL reset_outputs: clk_en=%b iso=%b gated=%b err=%b expected 11111/0/0/0",
                     clk_en, iso, gated, err);
        end
        checks++;
        if ({b_clk_en, b_iso, b_gated, b_err} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_outputs_b: got %b expected 1000", {b_clk_en, b_iso, b_gated, b_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clu_idle    = '1;
        gate_req[0] = 1'b1;
        tick();
        checks++;
        if (iso[0] !== 1'b1 || clk_en[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_drain_entry: iso=%b clk_en=%b expected iso=1 clk_en=1", iso[0], clk_en[0]);
        end
        for (int k = 1; k < IC; k++) begin
            tick();
            checks++;
            if (clk_en[0] !== 1'b1) begin
                failures++;
                $display("FAIL basic_drain_clk_en k=%0d: got %b expected 1", k, clk_en[0]);
            end
        end
        tick();
        checks++;
        if (clk_en[0] !== 1'b0 || gated[0] !== 1'b1 || iso[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_gated: clk_en=%b gated=%b iso=%b expected 0/1/1", clk_en[0], gated[0], iso[0]);
        end
        repeat (5) tick();
        gate_req[0] = 1'b0;
        tick();
        checks++;
        if (clk_en[0] !== 1'b1 || gated[0] !== 1'b0 || iso[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_wake_entry: clk_en=%b gated=%b iso=%b expected 1/0/1", clk_en[0], gated[0], iso[0]);
        end
        for (int k = 1; k < WC; k++) begin
            tick();
            checks++;
            if (iso[0] !== 1'b1) begin
                failures++;
                $display("FAIL basic_wake_iso k=%0d: got %b expected 1", k, iso[0]);
            end
        end
        tick();
        checks++;
        if (iso[0] !== 1'b0 || clk_en[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_run_again: iso=%b clk_en=%b expected 0/1", iso[0], clk_en[0]);
        end
    endtask

    task automatic test_idle_glitch();
        logic [7:0] pat;
        pat         = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1
        gate_req[0] = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            clu_idle[0] = pat[k];
            tick();
            checks++;
            if (clk_en[0] !== ((k == 7) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("FAIL glitch_clk_en k=%0d: got %b expected %b", k, clk_en[0], (k == 7) ? 1'b0 : 1'b1);
            end
        end
        gate_req[0] = 1'b0;
        clu_idle    = '1;
        repeat (WC + 1) tick();
        checks++;
        if (iso[0] !== 1'b0 || gated[0] !== 1'b0) begin
            failures++;
            $display("FAIL glitch_recover: iso=%b gated=%b expected 0/0", iso[0], gated[0]);
        end
    endtask

    task automatic test_timeout();
        clu_idle[2] = 1'b0;
        gate_req[2] = 1'b1;
        tick();
        for (int k = 1; k < TC; k++) begin
            tick();
            checks++;
            if (iso[2] !== 1'b1 || err[2] !== 1'b0) begin
                failures++;
                $display("FAIL timeout_draining k=%0d: iso=%b err=%b expected 1/0", k, iso[2], err[2]);
            end
        end
        tick();
        checks++;
        if (iso[2] !== 1'b0 || err[2] !== 1'b1 || clk_en[2] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort: iso=%b err=%b clk_en=%b expected 0/1/1", iso[2], err[2], clk_en[2]);
        end
        repeat (3) tick();
        checks++;
        if (iso[2] !== 1'b0 || err[2] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_blocks: iso=%b err=%b expected 0/1", iso[2], err[2]);
        end
        err_clr[2] = 1'b1;
        tick();
        err_clr[2] = 1'b0;
        checks++;
        if (err[2] !== 1'b0 || iso[2] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: err=%b iso=%b expected 0/0", err[2], iso[2]);
        end
        tick();
        checks++;
        if (iso[2] !== 1'b1) begin
            failures++;
            $display("FAIL timeout_redrain: iso=%b expected 1", iso[2]);
        end
        gate_req[2] = 1'b0;
        tick();
        checks++;
        if (iso[2] !== 1'b0 || err[2] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_exit: iso=%b err=%b expected 0/0", iso[2], err[2]);
        end
        clu_idle[2] = 1'b1;
    endtask

    task automatic test_abort();
        clu_idle[1] = 1'b0;
        gate_req[1] = 1'b1;
        repeat (3) tick();
        checks++;
        if (iso[1] !== 1'b1) begin
            failures++;
            $display("FAIL abort_draining: iso=%b expected 1", iso[1]);
        end
        gate_req[1] = 1'b0;
        tick();
        checks++;
        if (iso[1] !== 1'b0 || err[1] !== 1'b0 || clk_en[1] !== 1'b1) begin
            failures++;
            $display("FAIL abort_run: iso=%b err=%b clk_en=%b expected 0/0/1", iso[1], err[1], clk_en[1]);
        end
        clu_idle[1] = 1'b1;
    endtask

    task automatic test_simultaneous();
        b_idle = 1'b1;
        b_gate = 1'b1;
        tick();
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++;
            if (b_clk_en !== 1'b1 || b_err !== 1'b0) begin
                failures++;
                $display("FAIL simul_drain k=%0d: clk_en=%b err=%b expected 1/0", k, b_clk_en, b_err);
            end
        end
        tick();
        checks++;
        if (b_clk_en !== 1'b0 || b_gated !== 1'b1 || b_err !== 1'b0) begin
            failures++;
            $display("FAIL simul_gated: clk_en=%b gated=%b err=%b expected 0/1/0", b_clk_en, b_gated, b_err);
        end
        b_gate = 1'b0;
        repeat (WC + 1) tick();
        checks++;
        if (b_iso !== 1'b0 || b_gated !== 1'b0 || b_err !== 1'b0) begin
            failures++;
            $display("FAIL simul_recover: iso=%b gated=%b err=%b expected 0/0/0", b_iso, b_gated, b_err);
        end
    endtask

    task automatic test_independence();
        logic [7:0]      idle_pat [NC];
        logic [4*NC-1:0] exp;
        idle_pat[0] = 8'hFF;
        idle_pat[1] = 8'hEF;
        idle_pat[2] = 8'hB7;
        idle_pat[3] = 8'h7D;
        idle_pat[4] = 8'h00;  // never idle: runs into the timeout
        for (int cyc = 0; cyc < 45; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                if (cyc == 3 * c)  gate_req[c] = 1'b1;
                if (cyc == 28 + c) gate_req[c] = 1'b0;
                clu_idle[c] = idle_pat[c][cyc % 8];
            end
            tick();
            exp = model_outs();
            checks++;
            if ({clk_en, iso, gated, err} !== exp) begin
                failures++;
                $display("FAIL indep cyc=%0d: got %h expected %h", cyc, {clk_en, iso, gated, err}, exp);
            end
        end
        clu_idle = '1;
    endtask

    task automatic test_random();
        logic [4*NC-1:0] exp;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 7) == 0) gate_req[c] = ~gate_req[c];
                clu_idle[c] = ($urandom_range(0, 9) >= 2 * c);
                err_clr[c]  = ($urandom_range(0, 15) == 0);
            end
            tick();
            exp = model_outs();
            checks++;
            if ({clk_en, iso, gated, err} !== exp) begin
                failures++;
                $display("FAIL random cyc=%0d: got %h expected %h", cyc, {clk_en, iso, gated, err}, exp);
            end
        end
        err_clr = '0;
    endtask

    task automatic test_async_reset();
        logic [4*NC-1:0] exp;
        gate_req = '0;
        clu_idle = '1;
        err_clr  = '1;
        repeat (6) tick();
        err_clr     = '0;
        clu_idle[2] = 1'b0;
        gate_req[2] = 1'b1;
        gate_req[3] = 1'b1;
        repeat (TC + 1) tick();
        checks++;
        if (err[2] !== 1'b1 || gated[3] !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup: err2=%b gated3=%b expected 1/1", err[2], gated[3]);
        end
        gate_req[2] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clk_en !== '1 || iso !== '0 || gated !== '0 || err !== '0) begin
            failures++;
            $display("FAIL areset_immediate: clk_en=%b iso=%b gated=%b err=%b expected 11111/0/0/0",
                     clk_en, iso, gated, err);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (iso[3] !== 1'b1 || clk_en[3] !== 1'b1 || iso[2] !== 1'b0) begin
            failures++;
            $display("FAIL areset_redrain: iso3=%b clk_en3=%b iso2=%b expected 1/1/0", iso[3], clk_en[3], iso[2]);
        end
        exp = model_outs();
        checks++;
        if ({clk_en, iso, gated, err} !== exp) begin
            failures++;
            $display("FAIL areset_model: got %h expected %h", {clk_en, iso, gated, err}, exp);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n    = 1'b0;
        gate_req = '0;
        clu_idle = '0;
        err_clr  = '0;
        b_gate   = 1'b0;
        b_idle   = 1'b0;
        b_clr    = 1'b0;
        test_reset();
        test_basic();
        test_idle_glitch();
        test_timeout();
        test_abort();
        test_simultaneous();
        test_independence();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
